// File: rtl/dec_is_buffer.sv
// Decode-to-issue decoupling FIFO: first-word fall-through, per-entry sequence
// tags for age ordering, and a single-cycle flush that keeps the tag counter.
`ifndef AddrWidth
`define AddrWidth 32
`endif

module dec_is_buffer #(
  parameter int unsigned ADDR  = `AddrWidth,
  parameter int unsigned PKT   = 64,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SEQ   = 8
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic                     flush,
  input  logic                     dec_valid,
  input  logic [ADDR-1:0]          dec_pc,
  input  logic [PKT-1:0]           dec_pkt,
  output logic                     dec_stall,
  output logic                     is_valid,
  output logic [ADDR-1:0]          is_pc,
  output logic [PKT-1:0]           is_pkt,
  output logic [SEQ-1:0]           is_seq,
  input  logic                     is_stall,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [ADDR-1:0] pc;
    logic [PKT-1:0]  pkt;
    logic [SEQ-1:0]  seq;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic [SEQ-1:0]  seq_q, seq_d;
  logic            push_c;
  logic            pop_c;
  entry_t          head_ent_c;

  // Stall looks only at registered occupancy, so issue never reaches decode combinationally.
  assign dec_stall  = (count_q == CntW'(DEPTH));
  assign is_valid   = (count_q != '0) && !flush;
  assign push_c     = dec_valid && !dec_stall && !flush;
  assign pop_c      = is_valid && !is_stall;
  assign head_ent_c = mem_q[head_q];
  assign is_pc      = head_ent_c.pc;
  assign is_pkt     = head_ent_c.pkt;
  assign is_seq     = reset_ ? head_ent_c.seq : '0;
  assign count      = count_q;

  // Next-state for pointers, occupancy and tag counter; flush wins over push/pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    seq_d   = seq_q;
    if (push_c) begin
      seq_d = seq_q + SEQ'(1);
    end
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_c) tail_d = tail_q + PtrW'(1);
      if (pop_c)  head_d = head_q + PtrW'(1);
      if (push_c && !pop_c)      count_d = count_q + CntW'(1);
      else if (pop_c && !push_c) count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      seq_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      seq_q   <= seq_d;
    end
  end

  // Payload storage carries no reset; occupancy alone qualifies it.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[tail_q] <= '{pc: dec_pc, pkt: dec_pkt, seq: seq_q};
    end
  end

endmodule

// File: tb/tb_dec_is_buffer.sv
// Bench for dec_is_buffer: directed vector table, queue-based reference model
// under random traffic, tag wrap run and asynchronous mid-burst reset.
module tb_dec_is_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_;
  logic        flush;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [63:0] dec_pkt;
  logic        dec_stall;
  logic        is_valid;
  logic [31:0] is_pc;
  logic [63:0] is_pkt;
  logic [7:0]  is_seq;
  logic        is_stall;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  dec_is_buffer #(.ADDR(32), .PKT(64), .DEPTH(DEPTH), .SEQ(8)) dut (
    .clk(clk), .reset_(reset_), .flush(flush),
    .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_pkt(dec_pkt), .dec_stall(dec_stall),
    .is_valid(is_valid), .is_pc(is_pc), .is_pkt(is_pkt), .is_seq(is_seq),
    .is_stall(is_stall), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [63:0] pkt;
    logic [7:0]  seq;
  } ent_t;

  ent_t mq[$];
  int   mseq = 0;

  typedef struct {
    bit          v;
    logic [31:0] pc;
    bit          st;
    bit          fl;
    bit          ev;
    logic [31:0] epc;
    logic [7:0]  eseq;
    int          ecnt;
    bit          eds;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input bit st, input bit fl);
    dec_valid = v;
    dec_pc    = pc;
    dec_pkt   = {$urandom, $urandom};
    is_stall  = st;
    flush     = fl;
    #3;
  endtask

  // Reference: FIFO queue; outputs reflect pre-edge contents, then apply the edge.
  task automatic model_step();
    bit   ev;
    bit   full;
    ent_t e;
    ev   = (mq.size() != 0) && !flush;
    full = (mq.size() == DEPTH);
    chk("count", 64'(count), 64'(mq.size()));
    chk("dec_stall", 64'(dec_stall), 64'(full));
    chk("is_valid", 64'(is_valid), 64'(ev));
    if (ev) begin
      chk("is_pc", 64'(is_pc), 64'(mq[0].pc));
      chk("is_pkt", is_pkt, mq[0].pkt);
      chk("is_seq", 64'(is_seq), 64'(mq[0].seq));
    end
    if (flush) begin
      mq.delete();
    end else begin
      if (ev && !is_stall) void'(mq.pop_front());
      if (dec_valid && !full) begin
        e.pc  = dec_pc;
        e.pkt = dec_pkt;
        e.seq = 8'(mseq);
        mq.push_back(e);
        mseq = (mseq + 1) % 256;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_    = 1'b0;
    flush     = 1'b0;
    dec_valid = 1'b0;
    dec_pc    = '0;
    dec_pkt   = '0;
    is_stall  = 1'b0;

    //           v  pc        st fl  ev epc       eseq ecnt eds
    tbl[0]  = '{1, 32'h100, 0, 0,  0, 32'h0,   8'd0, 0, 0};
    tbl[1]  = '{1, 32'h104, 0, 0,  1, 32'h100, 8'd0, 1, 0};
    tbl[2]  = '{1, 32'h108, 0, 0,  1, 32'h104, 8'd1, 1, 0};
    tbl[3]  = '{0, 32'h0,   0, 0,  1, 32'h108, 8'd2, 1, 0};
    tbl[4]  = '{0, 32'h0,   1, 0,  0, 32'h0,   8'd0, 0, 0};
    tbl[5]  = '{1, 32'h100, 1, 0,  0, 32'h0,   8'd0, 0, 0};
    tbl[6]  = '{1, 32'h104, 1, 0,  1, 32'h100, 8'd3, 1, 0};
    tbl[7]  = '{1, 32'h108, 1, 0,  1, 32'h100, 8'd3, 2, 0};
    tbl[8]  = '{1, 32'h10C, 1, 0,  1, 32'h100, 8'd3, 3, 0};
    tbl[9]  = '{1, 32'h110, 1, 0,  1, 32'h100, 8'd3, 4, 1};
    tbl[10] = '{1, 32'h110, 0, 0,  1, 32'h100, 8'd3, 4, 1};
    tbl[11] = '{1, 32'h110, 0, 0,  1, 32'h104, 8'd4, 3, 0};
    tbl[12] = '{0, 32'h0,   0, 0,  1, 32'h108, 8'd5, 3, 0};
    tbl[13] = '{1, 32'h114, 1, 0,  1, 32'h10C, 8'd6, 2, 0};
    tbl[14] = '{1, 32'h118, 0, 1,  0, 32'h0,   8'd0, 3, 0};
    tbl[15] = '{1, 32'h11C, 0, 0,  0, 32'h0,   8'd0, 0, 0};
    tbl[16] = '{0, 32'h0,   0, 0,  1, 32'h11C, 8'd9, 1, 0};
    tbl[17] = '{0, 32'h0,   0, 0,  0, 32'h0,   8'd0, 0, 0};

    #2;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(is_valid), 64'd0);
    chk("rst_dec_stall", 64'(dec_stall), 64'd0);
    chk("rst_is_seq", 64'(is_seq), 64'd0);
    #20;
    reset_ = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].v, tbl[i].pc, tbl[i].st, tbl[i].fl);
      chk($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].ecnt));
      chk($sformatf("tbl%0d_dec_stall", i), 64'(dec_stall), 64'(tbl[i].eds));
      chk($sformatf("tbl%0d_valid", i), 64'(is_valid), 64'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_pc", i), 64'(is_pc), 64'(tbl[i].epc));
        chk($sformatf("tbl%0d_seq", i), 64'(is_seq), 64'(tbl[i].eseq));
      end
      model_step();
    end

    // Random traffic with occasional flushes.
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) == 0,
            $urandom_range(0, 15) == 0);
      model_step();
    end

    // Long streaming run: tag counter and pointers wrap many times.
    for (int i = 0; i < 270; i++) begin
      drive(1'b1, 32'h1000 + 32'(i * 4), $urandom_range(0, 4) == 0, 1'b0);
      model_step();
    end

    // Empty via flush, then build two entries and reset asynchronously.
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    model_step();
    drive(1'b1, 32'h2000, 1'b1, 1'b0);
    model_step();
    drive(1'b1, 32'h2004, 1'b1, 1'b0);
    model_step();
    dec_valid = 1'b1;
    is_stall  = 1'b1;
    #2;
    chk("pre_reset_count", 64'(count), 64'd2);
    reset_ = 1'b0;
    #1;
    chk("async_count", 64'(count), 64'd0);
    chk("async_valid", 64'(is_valid), 64'd0);
    chk("async_dec_stall", 64'(dec_stall), 64'd0);
    chk("async_is_seq", 64'(is_seq), 64'd0);
    mq.delete();
    mseq      = 0;
    dec_valid = 1'b0;
    @(posedge clk);
    #3;
    reset_ = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h3000 + 32'(i * 4), 1'b0, 1'b0);
      model_step();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    model_step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
